// File: rtl/sig_event_monitor.sv
// sig_event_monitor
//   Watches one single-bit waveform and produces registered equivalents of
//   $past/$rose/$fell/$stable/$changed. It also checks two rules:
//   - hold: after a rising sample, sig must stay high for HOLD_HIGH samples;
//     after a falling sample, sig must stay low for HOLD_LOW samples.
//   - toggle (optional): sig must change on every sample.
//   Violations raise one-cycle error pulses, and completed holds raise
//   one-cycle cover pulses.
//
// Ports
//   clk            sampling clock, rising edge
//   rst            asynchronous reset, active-high
//   en             check enable; the sample history updates regardless
//   sig            monitored signal
//   past_valid     high once a sample has been taken since reset
//   past_sig       sig as sampled at the previous edge
//   rose/fell      combinational edge detect against past_sig
//   changed/stable combinational change / no-change (both 0 before past_valid)
//   err_rose_hold  pulse: high hold broken
//   err_fell_hold  pulse: low hold broken
//   err_toggle     pulse: stable sample while TOGGLE_CHK=1
//   err_sticky     OR of every error pulse since reset
//   cov_hold_hi    pulse: rise followed by HOLD_HIGH ones
//   cov_hold_lo    pulse: fall followed by HOLD_LOW zeros
//   rose_cnt       enabled rising edges, saturating
//   fell_cnt       enabled falling edges, saturating
module sig_event_monitor #(
    parameter int HOLD_HIGH  = 4,
    parameter int HOLD_LOW   = 4,
    parameter bit TOGGLE_CHK = 1'b0,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sig,
    output logic             past_valid,
    output logic             past_sig,
    output logic             rose,
    output logic             fell,
    output logic             changed,
    output logic             stable,
    output logic             err_rose_hold,
    output logic             err_fell_hold,
    output logic             err_toggle,
    output logic             err_sticky,
    output logic             cov_hold_hi,
    output logic             cov_hold_lo,
    output logic [CNT_W-1:0] rose_cnt,
    output logic [CNT_W-1:0] fell_cnt
);

    typedef enum logic [1:0] {IDLE, HOLD_HI, HOLD_LO} state_t;

    state_t     state, state_nxt;
    logic [7:0] hcnt, hcnt_nxt;
    logic       err_rh_nxt, err_fh_nxt, err_tg_nxt, cov_hi_nxt, cov_lo_nxt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign rose    = past_valid & sig & ~past_sig;
    assign fell    = past_valid & ~sig & past_sig;
    assign changed = rose | fell;
    assign stable  = past_valid & ~changed;

    // State register, sample history, registered pulses and counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            past_valid    <= 1'b0;
            past_sig      <= 1'b0;
            state         <= IDLE;
            hcnt          <= '0;
            err_rose_hold <= 1'b0;
            err_fell_hold <= 1'b0;
            err_toggle    <= 1'b0;
            err_sticky    <= 1'b0;
            cov_hold_hi   <= 1'b0;
            cov_hold_lo   <= 1'b0;
            rose_cnt      <= '0;
            fell_cnt      <= '0;
        end else begin
            past_valid    <= 1'b1;
            past_sig      <= sig;
            state         <= state_nxt;
            hcnt          <= hcnt_nxt;
            err_rose_hold <= err_rh_nxt;
            err_fell_hold <= err_fh_nxt;
            err_toggle    <= err_tg_nxt;
            err_sticky    <= err_sticky | err_rh_nxt | err_fh_nxt | err_tg_nxt;
            cov_hold_hi   <= cov_hi_nxt;
            cov_hold_lo   <= cov_lo_nxt;
            if (en && rose) rose_cnt <= sat_inc(rose_cnt);
            if (en && fell) fell_cnt <= sat_inc(fell_cnt);
        end
    end

    // Next-state logic. A broken hold is itself the opposite edge, so it
    // re-arms the opposite hold directly instead of passing through IDLE.
    always_comb begin
        state_nxt = state;
        hcnt_nxt  = hcnt;
        if (!en) begin
            state_nxt = IDLE;
            hcnt_nxt  = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rose) begin
                        state_nxt = HOLD_HI;
                        hcnt_nxt  = 8'(HOLD_HIGH);
                    end else if (fell) begin
                        state_nxt = HOLD_LO;
                        hcnt_nxt  = 8'(HOLD_LOW);
                    end
                end
                HOLD_HI: begin
                    if (!sig) begin
                        state_nxt = HOLD_LO;
                        hcnt_nxt  = 8'(HOLD_LOW);
                    end else if (hcnt == 8'd1) begin
                        state_nxt = IDLE;
                        hcnt_nxt  = '0;
                    end else begin
                        hcnt_nxt  = hcnt - 8'd1;
                    end
                end
                HOLD_LO: begin
                    if (sig) begin
                        state_nxt = HOLD_HI;
                        hcnt_nxt  = 8'(HOLD_HIGH);
                    end else if (hcnt == 8'd1) begin
                        state_nxt = IDLE;
                        hcnt_nxt  = '0;
                    end else begin
                        hcnt_nxt  = hcnt - 8'd1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    hcnt_nxt  = '0;
                end
            endcase
        end
    end

    // Pulse decode; these become visible one cycle after the deciding sample
    always_comb begin
        err_rh_nxt = en && (state == HOLD_HI) && !sig;
        err_fh_nxt = en && (state == HOLD_LO) && sig;
        cov_hi_nxt = en && (state == HOLD_HI) && sig && (hcnt == 8'd1);
        cov_lo_nxt = en && (state == HOLD_LO) && !sig && (hcnt == 8'd1);
        err_tg_nxt = TOGGLE_CHK && en && stable;
    end

endmodule
